// File: rtl/hidden_layer_accumulator_pkg.sv
// Shared global constants for the hidden-layer engine: layer sizes, boolean
// levels, controller state encodings and accumulator sizing helper.
package hidden_layer_accumulator_pkg;

  localparam int INPUT_LAYER_NODES  = 784;
  localparam int HIDDEN_LAYER_NODES = 16;
  localparam int INDEX_WIDTH        = 10;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    DEQ_HI   = 3'd2,
    DEQ_LO   = 3'd3,
    MAC      = 3'd4,
    ACTIVATE = 3'd5
  } state_t;

  // Smallest signed width that holds terms * (most negative weight) without wrap.
  function automatic int min_acc_width(input int terms, input int weight_width);
    return $clog2(terms * (1 << (weight_width - 1))) + 1;
  endfunction

endpackage

// File: rtl/hidden_layer_accumulator_if.sv
// Bundle of the input-queue handshake, weight-ROM port and activation result
// seen by the hidden-layer accumulator.
interface hidden_layer_accumulator_if
  import hidden_layer_accumulator_pkg::*;
#(
  parameter int NUM_NODES    = HIDDEN_LAYER_NODES,
  parameter int WEIGHT_WIDTH = 8
);

  localparam int ADDR_WIDTH = INDEX_WIDTH + $clog2(NUM_NODES);

  logic                           start;
  logic [INDEX_WIDTH-1:0]         indexIn;
  logic                           queueEmpty;
  logic                           dequeue;
  logic [ADDR_WIDTH-1:0]          weightAddr;
  logic signed [WEIGHT_WIDTH-1:0] weightData;
  logic [NUM_NODES-1:0]           nodeOut;
  logic                           busy;
  logic                           done;

  modport master (
    output start, indexIn, queueEmpty, weightData,
    input  dequeue, weightAddr, nodeOut, busy, done
  );

  modport slave (
    input  start, indexIn, queueEmpty, weightData,
    output dequeue, weightAddr, nodeOut, busy, done
  );

endinterface

// File: rtl/hidden_layer_accumulator_node_accumulator_bank.sv
// One signed accumulator per hidden node, with sign-extended weight add,
// synchronous clear and a per-node threshold compare.
module node_accumulator_bank #(
  parameter int NUM_NODES    = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 18,
  parameter logic signed [ACC_WIDTH-1:0] THRESHOLD = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           add_en,
  input  logic [$clog2(NUM_NODES)-1:0]   add_node,
  input  logic signed [WEIGHT_WIDTH-1:0] weight,
  output logic [NUM_NODES-1:0]           activation
);

  logic signed [ACC_WIDTH-1:0] acc [NUM_NODES];
  logic signed [ACC_WIDTH-1:0] weight_ext;

  assign weight_ext = {{(ACC_WIDTH-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < NUM_NODES; k++) begin
        acc[k] <= '0;
      end
    end else if (add_en) begin
      acc[add_node] <= acc[add_node] + weight_ext;
    end
  end

  always_comb begin
    activation = '0;
    for (int k = 0; k < NUM_NODES; k++) begin
      activation[k] = (acc[k] >= THRESHOLD);
    end
  end

endmodule

// File: rtl/hidden_layer_accumulator.sv
// Hidden-layer MAC controller: drains the pixel-index queue, streams one weight
// column per index into the node bank, then thresholds the sums into nodeOut.
module hidden_layer_accumulator
  import hidden_layer_accumulator_pkg::*;
#(
  parameter int NUM_NODES    = HIDDEN_LAYER_NODES,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = min_acc_width(INPUT_LAYER_NODES, 8),
  parameter logic signed [ACC_WIDTH-1:0] THRESHOLD = '0
) (
  input logic                       clk,
  input logic                       reset,
  hidden_layer_accumulator_if.slave bus
);

  localparam int NODE_BITS  = $clog2(NUM_NODES);
  localparam int ADDR_WIDTH = INDEX_WIDTH + NODE_BITS;

  state_t                  state;
  state_t                  next_state;
  logic [INDEX_WIDTH-1:0]  index_reg;
  logic [NODE_BITS:0]      node_count;
  logic                    add_en;
  logic [NODE_BITS-1:0]    add_node;
  logic [NUM_NODES-1:0]    activation;
  logic [NUM_NODES-1:0]    node_out_reg;
  logic                    done_reg;
  logic                    clear_acc;
  logic                    mac_issue;
  logic                    mac_last;
  logic                    dequeue;
  logic                    busy;
  logic [ADDR_WIDTH-1:0]   weight_addr;

  // The counter runs 0..NUM_NODES; its top bit marks the ROM-latency drain cycle.
  assign mac_issue = (state == MAC) && !node_count[NODE_BITS];
  assign mac_last  = (state == MAC) &&  node_count[NODE_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    dequeue     = FALSE;
    busy        = TRUE;
    clear_acc   = FALSE;
    weight_addr = '0;
    case (state)
      IDLE: begin
        busy = FALSE;
        if (bus.start) begin
          clear_acc  = TRUE;
          next_state = CHECK;
        end
      end
      CHECK: begin
        next_state = bus.queueEmpty ? ACTIVATE : DEQ_HI;
      end
      DEQ_HI: begin
        dequeue    = TRUE;
        next_state = DEQ_LO;
      end
      DEQ_LO: begin
        next_state = MAC;
      end
      MAC: begin
        if (mac_issue) begin
          weight_addr = {index_reg, node_count[NODE_BITS-1:0]};
        end
        if (mac_last) begin
          next_state = CHECK;
        end
      end
      ACTIVATE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ROM data lags its address by one cycle, so the target node is delayed to match.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_reg    <= '0;
      node_count   <= '0;
      add_en       <= 1'b0;
      add_node     <= '0;
      node_out_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      add_en   <= mac_issue;
      add_node <= node_count[NODE_BITS-1:0];
      done_reg <= (state == ACTIVATE);
      if (state == DEQ_LO) begin
        index_reg  <= bus.indexIn;
        node_count <= '0;
      end else if (state == MAC) begin
        node_count <= node_count + 1'b1;
      end
      if (state == ACTIVATE) begin
        node_out_reg <= activation;
      end
    end
  end

  node_accumulator_bank #(
    .NUM_NODES    (NUM_NODES),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH),
    .THRESHOLD    (THRESHOLD)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_acc),
    .add_en     (add_en),
    .add_node   (add_node),
    .weight     (bus.weightData),
    .activation (activation)
  );

  assign bus.dequeue    = dequeue;
  assign bus.busy       = busy;
  assign bus.weightAddr = weight_addr;
  assign bus.nodeOut    = node_out_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_hidden_layer_accumulator.sv
// Self-checking bench: queue and registered weight-ROM models drive the DUT;
// expected activations come from plain column sums over the frame.
module tb_hidden_layer_accumulator;

  localparam int NUM_NODES    = 16;
  localparam int WEIGHT_WIDTH = 8;
  localparam int ACC_WIDTH    = 18;
  localparam int THRESH       = 0;
  localparam int ADDR_WIDTH   = 14;
  localparam int TIMEOUT      = 20000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hidden_layer_accumulator_if #(.NUM_NODES(NUM_NODES), .WEIGHT_WIDTH(WEIGHT_WIDTH)) bus();

  hidden_layer_accumulator #(
    .NUM_NODES    (NUM_NODES),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH),
    .THRESHOLD    (18'sd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int deq_count = 0;
  logic signed [WEIGHT_WIDTH-1:0] rom [1 << ADDR_WIDTH];
  int q[$];
  int frame[$];

  // One clock: sample DUT requests, then answer them as the queue and ROM would.
  task automatic tick();
    logic [ADDR_WIDTH-1:0] addr;
    logic deq;
    addr = bus.weightAddr;
    deq  = bus.dequeue;
    @(posedge clk);
    #1;
    bus.weightData = rom[addr];
    if (deq) begin
      deq_count++;
      if (q.size() > 0) bus.indexIn = 10'(q.pop_front());
      bus.queueEmpty = (q.size() == 0);
    end
  endtask

  function automatic int model_sum(input int k);
    int s = 0;
    foreach (frame[i]) s += int'(rom[frame[i] * NUM_NODES + k]);
    return s;
  endfunction

  function automatic logic [NUM_NODES-1:0] model_out();
    logic [NUM_NODES-1:0] r;
    for (int k = 0; k < NUM_NODES; k++) r[k] = (model_sum(k) >= THRESH);
    return r;
  endfunction

  task automatic run_frame(input string tag, input int restart_at, output int latency,
                           output int done_pulses, output logic [NUM_NODES-1:0] result);
    q = frame;
    bus.queueEmpty = (q.size() == 0);
    deq_count = 0;
    latency = -1;
    done_pulses = 0;
    result = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 1; n <= TIMEOUT; n++) begin
      if (bus.done) begin
        done_pulses++;
        if (latency < 0) begin
          latency = n;
          result = bus.nodeOut;
        end
      end
      if (latency >= 0 && n >= latency + 2) break;
      bus.start = (n == restart_at);
      tick();
    end
    bus.start = 1'b0;
    if (latency < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: no done within %0d cycles", tag, TIMEOUT);
    end
  endtask

  task automatic check_frame(input string tag, input int lat, input int pulses,
                             input logic [NUM_NODES-1:0] got);
    logic [NUM_NODES-1:0] exp;
    exp = model_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s_nodeOut: got %h expected %h", tag, got, exp);
    end
    checks++;
    if (lat !== 20 * frame.size() + 3) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d expected %0d", tag, lat, 20 * frame.size() + 3);
    end
    checks++;
    if (deq_count !== frame.size()) begin
      errors++;
      $display("[TB] FAIL %s_dequeues: got %0d expected %0d", tag, deq_count, frame.size());
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("[TB] FAIL %s_done_width: got %0d expected 1", tag, pulses);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.indexIn = '0;
    bus.queueEmpty = 1'b1;
    bus.weightData = '0;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.dequeue !== 1'b0) begin errors++; $display("[TB] FAIL reset_dequeue: got %b expected 0", bus.dequeue); end
    checks++; if (bus.nodeOut !== 16'h0000) begin errors++; $display("[TB] FAIL reset_nodeOut: got %h expected 0000", bus.nodeOut); end
    checks++; if (bus.weightAddr !== 14'h0) begin errors++; $display("[TB] FAIL reset_weightAddr: got %h expected 0", bus.weightAddr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, pulses, a;
    logic [NUM_NODES-1:0] got;
    foreach (rom[i]) rom[i] = 8'((i % NUM_NODES) - 8);
    frame = '{3, 5};
    run_frame("basic", 0, lat, pulses, got);
    check_frame("basic", lat, pulses, got);
    checks++;
    if (got !== 16'hFF00) begin errors++; $display("[TB] FAIL basic_pattern: got %h expected ff00", got); end
    for (int k = 0; k < NUM_NODES; k++) begin
      a = dut.u_bank.acc[k];
      checks++;
      if (a !== 2 * (k - 8)) begin
        errors++;
        $display("[TB] FAIL basic_acc%0d: got %0d expected %0d", k, a, 2 * (k - 8));
      end
    end
  endtask

  task automatic test_empty();
    int lat, pulses;
    logic [NUM_NODES-1:0] got;
    frame.delete();
    run_frame("empty", 0, lat, pulses, got);
    check_frame("empty", lat, pulses, got);
    checks++;
    if (got !== 16'hFFFF) begin errors++; $display("[TB] FAIL empty_allones: got %h expected ffff", got); end
  endtask

  task automatic test_random();
    int lat, pulses, len;
    logic [NUM_NODES-1:0] got;
    for (int it = 0; it < 6; it++) begin
      foreach (rom[i]) rom[i] = 8'($urandom);
      frame.delete();
      len = $urandom_range(1, 5);
      repeat (len) frame.push_back(int'($urandom_range(0, 1023)));
      run_frame("random", 0, lat, pulses, got);
      check_frame("random", lat, pulses, got);
    end
  endtask

  task automatic test_full_frame();
    int lat, pulses, a;
    logic [NUM_NODES-1:0] got;
    foreach (rom[i]) rom[i] = -8'sd128;
    frame.delete();
    for (int i = 0; i < 784; i++) frame.push_back(int'($urandom_range(0, 1023)));
    run_frame("full", 0, lat, pulses, got);
    check_frame("full", lat, pulses, got);
    for (int k = 0; k < NUM_NODES; k++) begin
      a = dut.u_bank.acc[k];
      checks++;
      if (a !== -100352) begin
        errors++;
        $display("[TB] FAIL full_acc%0d: got %0d expected -100352", k, a);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    int lat, pulses;
    logic [NUM_NODES-1:0] got;
    frame.delete();
    run_frame("preload", 0, lat, pulses, got);
    foreach (rom[i]) rom[i] = 8'($urandom);
    frame = '{7, 9};
    q = frame;
    bus.queueEmpty = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    checks++;
    if (bus.weightAddr !== 14'((7 << 4) | 6)) begin
      errors++;
      $display("[TB] FAIL midmac_addr: got %h expected %h", bus.weightAddr, 14'((7 << 4) | 6));
    end
    reset = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midmac_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.dequeue !== 1'b0) begin errors++; $display("[TB] FAIL midmac_dequeue: got %b expected 0", bus.dequeue); end
    checks++; if (bus.nodeOut !== 16'h0000) begin errors++; $display("[TB] FAIL midmac_nodeOut: got %h expected 0000", bus.nodeOut); end
    checks++; if (bus.weightAddr !== 14'h0) begin errors++; $display("[TB] FAIL midmac_weightAddr: got %h expected 0", bus.weightAddr); end
    reset = 1'b0;
    tick();
    frame = '{int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023))};
    run_frame("after_reset", 0, lat, pulses, got);
    check_frame("after_reset", lat, pulses, got);
  endtask

  task automatic test_restart_ignored();
    int lat, pulses;
    logic [NUM_NODES-1:0] got;
    foreach (rom[i]) rom[i] = 8'($urandom);
    frame = '{int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023))};
    run_frame("restart_mac", 5, lat, pulses, got);
    check_frame("restart_mac", lat, pulses, got);
    run_frame("restart_act", 20 * 3 + 2, lat, pulses, got);
    check_frame("restart_act", lat, pulses, got);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_idle: got busy %b expected 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_random();
    test_full_frame();
    test_reset_mid_mac();
    test_restart_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
